ddr2_ex_pattern_ctrl: RTL and testbench
=======================================

Name: ddr2_ex_pattern_ctrl

Overview:
Sequencer for the DDR2 example-driver test pattern path. It drives two external 8-bit LFSR instances: a write-pattern generator and a read-expected generator. It runs one write pass followed by one read-and-compare pass over a contiguous address range on the local (controller-side) interface. It reports pass/fail, an error count and the first failing address.

Parameters:
ADDR_W, 8, width of local_address and num_words
TIMEOUT, 1024, maximum idle cycles in the read-wait phase before the pass aborts (must be ≥ 2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a test pass
num_words  input  ADDR_W  number of words to write and read, sampled on an accepted start
local_ready  input  1  controller accepts the current request this cycle
local_write_req  output  1  write request
local_read_req  output  1  read request
local_address  output  ADDR_W  word address of the current request
local_wdata  output  8  write data (equals wr_lfsr_data)
local_rdata_valid  input  1  read data valid
local_rdata  input  8  returned read data
wr_lfsr_enable  output  1  write LFSR enable (0 holds it at seed)
wr_lfsr_pause  output  1  write LFSR pause
wr_lfsr_data  input  8  write LFSR output
rd_lfsr_enable  output  1  read LFSR enable
rd_lfsr_pause  output  1  read LFSR pause
rd_lfsr_data  input  8  read LFSR output (expected data)
done  output  1  test pass complete; held until the next accepted start
pass  output  1  valid when done: no errors and no timeout
fail  output  1  valid when done: equals !pass
timeout  output  1  read-wait timeout occurred
err_count  output  8  mismatch count, saturates at 255
first_err_addr  output  ADDR_W  address of the first mismatch (0 if none)

Behaviour:
- Reset: state IDLE. All outputs are 0 and all counters are cleared.
- States: IDLE, WRITE, READ, WAIT_RD, DONE.
- start is accepted only in IDLE or DONE and is ignored elsewhere.
- On an accepted start:
  - clear done, pass, fail, timeout, err_count, first_err_addr, wr_addr, rd_issue and rd_ret;
  - latch num_words into nw;
  - if nw == 0, go to DONE with pass = 1; otherwise go to WRITE.
- LFSR enable rules:
  - wr_lfsr_enable = 1 only in WRITE;
  - rd_lfsr_enable = 1 only in READ and WAIT_RD;
  - at all other times both are 0, so each LFSR restarts from its seed on every pass.
- WRITE:
  - local_write_req = 1, local_address = wr_addr, local_wdata = wr_lfsr_data;
  - wr_lfsr_pause = !local_ready (combinational), so the LFSR advances exactly once per accepted word;
  - address and data stay stable while local_ready = 0;
  - on acceptance with wr_addr == nw-1, go to READ and clear the address; otherwise wr_addr increments.
- READ:
  - local_read_req = 1, local_address = rd_issue;
  - rd_issue increments on local_ready;
  - on acceptance of the last issue, go to WAIT_RD, or go directly to DONE if rd_ret has already reached nw in that cycle.
- Return handling (READ and WAIT_RD):
  - rd_lfsr_pause = !local_rdata_valid;
  - on each valid cycle, compare local_rdata with rd_lfsr_data, then increment rd_ret;
  - on mismatch, err_count increments (saturating at 255); if it was 0, first_err_addr = rd_ret;
  - returns arrive in issue order; local_rdata_valid outside READ/WAIT_RD is ignored.
- WAIT_RD:
  - no requests are issued;
  - go to DONE when rd_ret reaches nw;
  - an idle counter clears on every valid cycle and on entry; when it reaches TIMEOUT, set timeout = 1 and go to DONE.
- DONE:
  - done = 1, pass = (err_count == 0 && !timeout), fail = !pass;
  - requests and LFSR enables are 0;
  - status holds until the next accepted start.
- Reset asserted mid-operation: return to IDLE immediately and abandon outstanding reads.
- LFSR reference sequence (seed 32, used by the bench): 0x20, 0x40, 0x80, 0x1D, 0x3A.

Test Plan:
1. num_words = 4, local_ready = 1, memory model echoes writes with 2-cycle latency -> writes 0x20/0x40/0x80/0x1D at addresses 0–3; reads of addresses 0–3; done = 1, pass = 1, err_count = 0, timeout = 0.
2. num_words = 4, local_ready toggling 1-0-1-0 -> each write data and address held across ready = 0; exactly 4 writes with no duplicates or skips; pass = 1.
3. As scenario 1 but address 2 returns 0x81 -> err_count = 1, first_err_addr = 2, fail = 1, pass = 0.
4. num_words = 3, model never asserts local_rdata_valid -> timeout = 1 and fail = 1 exactly TIMEOUT cycles after entering WAIT_RD.
5. reset pulsed during WRITE after 2 words -> all outputs 0 and both LFSR enables 0; a following start writes 0x20 at address 0 again.
6. num_words = 0 -> done = 1 and pass = 1 one cycle after start, with no requests issued; start asserted during WRITE -> ignored, pass completes normally.

Source files
------------

// File: rtl/ddr2_ex_pattern_ctrl_if.sv
// Local (controller-side) request/return bus used by the DDR2 example pattern sequencer.
// The master issues write/read requests; the slave accepts them and returns read data in order.
interface ddr2_ex_pattern_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              local_ready;
    logic              local_write_req;
    logic              local_read_req;
    logic [ADDR_W-1:0] local_address;
    logic [7:0]        local_wdata;
    logic              local_rdata_valid;
    logic [7:0]        local_rdata;

    modport master (
        input  local_ready,
        input  local_rdata_valid,
        input  local_rdata,
        output local_write_req,
        output local_read_req,
        output local_address,
        output local_wdata
    );

    modport slave (
        output local_ready,
        output local_rdata_valid,
        output local_rdata,
        input  local_write_req,
        input  local_read_req,
        input  local_address,
        input  local_wdata
    );
endinterface

// File: rtl/ddr2_ex_pattern_ctrl.sv
// Write-then-read-compare sequencer for the DDR2 example driver. Steers two external
// 8-bit LFSRs (write pattern and read expected) and reports pass/fail status.
module ddr2_ex_pattern_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    num_words,
    ddr2_ex_pattern_ctrl_if.master lcl,
    output logic                 wr_lfsr_enable,
    output logic                 wr_lfsr_pause,
    input  logic [7:0]           wr_lfsr_data,
    output logic                 rd_lfsr_enable,
    output logic                 rd_lfsr_pause,
    input  logic [7:0]           rd_lfsr_data,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic                 timeout,
    output logic [7:0]           err_count,
    output logic [ADDR_W-1:0]    first_err_addr
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT_RD,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] nw;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_issue;
    logic [ADDR_W-1:0] rd_ret;
    logic [IDLE_W-1:0] idle_cnt;

    logic              in_write;
    logic              in_read;
    logic              in_rd_phase;
    logic              rd_hit;
    logic              rd_miss;
    logic [7:0]        err_nxt;
    logic [ADDR_W-1:0] ret_nxt;
    logic              last_wr;
    logic              last_rd;
    logic              ret_done;
    logic              pass_nxt;

    always_comb begin
        in_write    = (state == S_WRITE);
        in_read     = (state == S_READ);
        in_rd_phase = in_read || (state == S_WAIT_RD);
        rd_hit      = in_rd_phase && lcl.local_rdata_valid;
        rd_miss     = rd_hit && (lcl.local_rdata != rd_lfsr_data);
        err_nxt     = (rd_miss && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
        ret_nxt     = rd_hit ? rd_ret + ADDR_W'(1) : rd_ret;
        last_wr     = (wr_addr == nw - ADDR_W'(1));
        last_rd     = (rd_issue == nw - ADDR_W'(1));
        ret_done    = (ret_nxt == nw);
        // Includes a mismatch arriving in the same cycle the pass finishes.
        pass_nxt    = (err_nxt == 8'd0);
    end

    // Requests and LFSR controls are pure decodes of the state register; the pause
    // lines must follow ready/valid in the same cycle so each LFSR steps once per beat.
    assign lcl.local_write_req = in_write;
    assign lcl.local_read_req  = in_read;
    assign lcl.local_address   = in_write ? wr_addr : (in_read ? rd_issue : '0);
    assign lcl.local_wdata     = in_write ? wr_lfsr_data : 8'h00;

    assign wr_lfsr_enable = in_write;
    assign wr_lfsr_pause  = in_write && !lcl.local_ready;
    assign rd_lfsr_enable = in_rd_phase;
    assign rd_lfsr_pause  = in_rd_phase && !lcl.local_rdata_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            nw             <= '0;
            wr_addr        <= '0;
            rd_issue       <= '0;
            rd_ret         <= '0;
            idle_cnt       <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= 8'd0;
            first_err_addr <= '0;
        end else begin
            if (rd_hit) begin
                rd_ret    <= ret_nxt;
                err_count <= err_nxt;
                if (rd_miss && err_count == 8'd0) begin
                    first_err_addr <= rd_ret;
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        fail           <= 1'b0;
                        timeout        <= 1'b0;
                        err_count      <= 8'd0;
                        first_err_addr <= '0;
                        wr_addr        <= '0;
                        rd_issue       <= '0;
                        rd_ret         <= '0;
                        idle_cnt       <= '0;
                        nw             <= num_words;
                        if (num_words == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    if (lcl.local_ready) begin
                        if (last_wr) begin
                            wr_addr <= '0;
                            state   <= S_READ;
                        end else begin
                            wr_addr <= wr_addr + ADDR_W'(1);
                        end
                    end
                end

                S_READ: begin
                    if (lcl.local_ready) begin
                        rd_issue <= rd_issue + ADDR_W'(1);
                        if (last_rd) begin
                            if (ret_done) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                                pass  <= pass_nxt;
                                fail  <= !pass_nxt;
                            end else begin
                                state    <= S_WAIT_RD;
                                idle_cnt <= '0;
                            end
                        end
                    end
                end

                S_WAIT_RD: begin
                    if (ret_done) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        pass  <= pass_nxt;
                        fail  <= !pass_nxt;
                    end else if (rd_hit) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                        state   <= S_DONE;
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        fail    <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr2_ex_pattern_ctrl.sv
// Directed bench for ddr2_ex_pattern_ctrl: memory echo model with 2-cycle read latency,
// two seed-0x20 LFSR models, and hand-computed expectations per scenario.
module tb_ddr2_ex_pattern_ctrl;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] num_words;
    logic       wr_lfsr_enable, wr_lfsr_pause, rd_lfsr_enable, rd_lfsr_pause;
    logic [7:0] wr_lfsr_data, rd_lfsr_data;
    logic       done, pass, fail, timeout;
    logic [7:0] err_count, first_err_addr;

    ddr2_ex_pattern_ctrl_if #(.ADDR_W(8)) lcl ();

    ddr2_ex_pattern_ctrl #(.ADDR_W(8), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .num_words      (num_words),
        .lcl            (lcl),
        .wr_lfsr_enable (wr_lfsr_enable),
        .wr_lfsr_pause  (wr_lfsr_pause),
        .wr_lfsr_data   (wr_lfsr_data),
        .rd_lfsr_enable (rd_lfsr_enable),
        .rd_lfsr_pause  (rd_lfsr_pause),
        .rd_lfsr_data   (rd_lfsr_data),
        .done           (done),
        .pass           (pass),
        .fail           (fail),
        .timeout        (timeout),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_nxt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
    endfunction

    logic [7:0] wr_q = 8'h20;
    logic [7:0] rd_q = 8'h20;
    always @(posedge clk) begin
        if (!wr_lfsr_enable)    wr_q <= 8'h20;
        else if (!wr_lfsr_pause) wr_q <= lfsr_nxt(wr_q);
        if (!rd_lfsr_enable)    rd_q <= 8'h20;
        else if (!rd_lfsr_pause) rd_q <= lfsr_nxt(rd_q);
    end
    assign wr_lfsr_data = wr_q;
    assign rd_lfsr_data = rd_q;

    // Memory model, request logs and write-hold monitor
    logic       tog = 1'b0, corrupt = 1'b0, no_ret = 1'b0;
    logic       rdy_q = 1'b1;
    logic [7:0] mem [0:255];
    logic [7:0] wlog_a [64];
    logic [7:0] wlog_d [64];
    logic [7:0] rlog_a [64];
    int         wcnt = 0, rcnt = 0, hold_err = 0, hold_seen = 0;
    logic       rv1 = 1'b0, rv2 = 1'b0, hold_pend = 1'b0;
    logic [7:0] ra1 = 8'h00, ra2 = 8'h00, hold_a = 8'h00, hold_d = 8'h00;

    always @(posedge clk) begin
        rdy_q <= tog ? ~rdy_q : 1'b1;
        if (lcl.local_write_req && lcl.local_ready) begin
            mem[lcl.local_address] <= lcl.local_wdata;
            wlog_a[wcnt[5:0]]      <= lcl.local_address;
            wlog_d[wcnt[5:0]]      <= lcl.local_wdata;
            wcnt                   <= wcnt + 1;
        end
        if (lcl.local_read_req && lcl.local_ready) begin
            rlog_a[rcnt[5:0]] <= lcl.local_address;
            rcnt              <= rcnt + 1;
        end
        rv1 <= lcl.local_read_req && lcl.local_ready;
        ra1 <= lcl.local_address;
        rv2 <= rv1;
        ra2 <= ra1;
        if (hold_pend && lcl.local_write_req) begin
            hold_seen <= hold_seen + 1;
            if (lcl.local_address != hold_a || lcl.local_wdata != hold_d) hold_err <= hold_err + 1;
        end
        hold_pend <= lcl.local_write_req && !lcl.local_ready;
        hold_a    <= lcl.local_address;
        hold_d    <= lcl.local_wdata;
    end

    assign lcl.local_ready       = rdy_q;
    assign lcl.local_rdata_valid = rv2 && !no_ret;
    assign lcl.local_rdata       = (corrupt && ra2 == 8'd2) ? 8'h81 : mem[ra2];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [7:0] nw, input int budget);
        int cyc;
        @(negedge clk);
        start = 1'b1;
        num_words = nw;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_in_budget", done, 1);
    endtask

    logic [7:0] exp_seq [5] = '{8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};

    initial begin
        int wb, rb, k, idx;
        reset = 1'b1;
        start = 1'b0;
        num_words = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_status", {done, pass, fail, timeout}, 0);
        chk("rst_err", err_count, 0);
        chk("rst_first", first_err_addr, 0);
        chk("rst_req", {lcl.local_write_req, lcl.local_read_req}, 0);
        chk("rst_lfsr_en", {wr_lfsr_enable, rd_lfsr_enable}, 0);
        chk("rst_addr_data", {lcl.local_address, lcl.local_wdata}, 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: basic pass, ready always high
        wb = wcnt; rb = rcnt;
        run(8'd4, 200);
        chk("s1_wcount", wcnt - wb, 4);
        chk("s1_rcount", rcnt - rb, 4);
        for (int i = 0; i < 4; i++) begin
            idx = wb + i;
            chk("s1_waddr", wlog_a[idx[5:0]], i);
            chk("s1_wdata", wlog_d[idx[5:0]], exp_seq[i]);
            idx = rb + i;
            chk("s1_raddr", rlog_a[idx[5:0]], i);
        end
        chk("s1_status", {done, pass, fail, timeout}, 4'b1100);
        chk("s1_err", err_count, 0);

        // 2: ready toggling, writes must hold and never duplicate
        tog = 1'b1;
        wb = wcnt;
        run(8'd4, 300);
        tog = 1'b0;
        chk("s2_wcount", wcnt - wb, 4);
        for (int i = 0; i < 4; i++) begin
            idx = wb + i;
            chk("s2_waddr", wlog_a[idx[5:0]], i);
            chk("s2_wdata", wlog_d[idx[5:0]], exp_seq[i]);
        end
        chk("s2_hold_seen", hold_seen > 0, 1);
        chk("s2_hold_err", hold_err, 0);
        chk("s2_status", {done, pass, fail, timeout}, 4'b1100);

        // 3: corrupted return at address 2
        corrupt = 1'b1;
        run(8'd4, 200);
        corrupt = 1'b0;
        chk("s3_err", err_count, 1);
        chk("s3_first", first_err_addr, 2);
        chk("s3_status", {done, pass, fail, timeout}, 4'b1010);

        // 4: no returns -> timeout TO cycles after WAIT_RD entry
        no_ret = 1'b1;
        @(negedge clk);
        start = 1'b1;
        num_words = 8'd3;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(lcl.local_read_req && lcl.local_address == 8'd2) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("s4_last_issue_seen", k < 200, 1);
        @(posedge clk);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!done && k < 200);
        chk("s4_timeout_latency", k, TO);
        chk("s4_status", {done, pass, fail, timeout}, 4'b1011);
        no_ret = 1'b0;
        repeat (3) @(negedge clk);

        // 5: reset during WRITE after 2 words
        wb = wcnt;
        @(negedge clk);
        start = 1'b1;
        num_words = 8'd8;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (wcnt - wb < 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("s5_two_writes", wcnt - wb, 2);
        reset = 1'b1;
        #1;
        chk("s5_rst_status", {done, pass, fail, timeout}, 0);
        chk("s5_rst_req", {lcl.local_write_req, lcl.local_read_req}, 0);
        chk("s5_rst_lfsr_en", {wr_lfsr_enable, rd_lfsr_enable}, 0);
        chk("s5_rst_err", {err_count, first_err_addr}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        wb = wcnt;
        run(8'd2, 200);
        chk("s5_waddr0", wlog_a[wb[5:0]], 0);
        chk("s5_wdata0", wlog_d[wb[5:0]], 8'h20);
        chk("s5_status", {done, pass, fail, timeout}, 4'b1100);

        // 6: zero words, then start ignored during WRITE
        wb = wcnt; rb = rcnt;
        @(negedge clk);
        start = 1'b1;
        num_words = 8'd0;
        @(negedge clk);
        start = 1'b0;
        chk("s6_zero_done_pass", {done, pass, fail}, 3'b110);
        chk("s6_zero_noreq", {lcl.local_write_req, lcl.local_read_req}, 0);
        @(negedge clk);
        chk("s6_zero_counts", (wcnt - wb) + (rcnt - rb), 0);
        wb = wcnt; rb = rcnt;
        @(negedge clk);
        start = 1'b1;
        num_words = 8'd4;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (wcnt - wb < 1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        start = 1'b1;
        num_words = 8'd0;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("s6_done", done, 1);
        chk("s6_wcount", wcnt - wb, 4);
        chk("s6_rcount", rcnt - rb, 4);
        chk("s6_status", {done, pass, fail, timeout}, 4'b1100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
